// File: rtl/magic_device_reader_if.sv
// Request, response and magic-device bus bundle for magic_device_reader.
// slave is the reader's own view; master is the surrounding environment.
interface magic_device_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_select;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [11:0] resp_select;
  logic [11:0] dev_read_select;
  logic        dev_read_ready;
  logic        dev_read_valid;
  logic [63:0] dev_read_data;

  modport slave (
    input  req_valid, req_select, resp_ready, dev_read_valid, dev_read_data,
    output req_ready, resp_valid, resp_data, resp_select, dev_read_select, dev_read_ready
  );

  modport master (
    output req_valid, req_select, resp_ready, dev_read_valid, dev_read_data,
    input  req_ready, resp_valid, resp_data, resp_select, dev_read_select, dev_read_ready
  );
endinterface

// File: rtl/magic_device_reader.sv
// Serialises selector reads to the magic device and queues {selector, data} responses.
// Define MAGIC_READER_STATS_EN to add saturating stat_reads/stat_stalls counters.
module magic_device_reader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  magic_device_reader_if.slave bus,
  output logic                 busy
`ifdef MAGIC_READER_STATS_EN
  ,
  output logic [31:0]          stat_reads,
  output logic [31:0]          stat_stalls
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e          state_q, state_d;
  logic [11:0]     sel_q;
  logic [75:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic req_ready, dev_read_ready, push, pop, accept, full, not_empty;

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign not_empty = (count_q != '0);
  assign accept    = bus.req_valid && req_ready;
  assign pop       = not_empty && bus.resp_ready;

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    dev_read_ready = 1'b0;
    push           = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = !full && !reset;
        if (bus.req_valid && req_ready) state_d = StIssue;
      end
      StIssue: begin
        dev_read_ready = 1'b1;
        if (bus.dev_read_valid) state_d = StCapture;
      end
      StCapture: begin
        // Space is guaranteed: accept required count < depth and only pops happened since.
        push    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) sel_q <= bus.req_select;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; an aborted capture must not write it either.
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_ptr_q] <= {sel_q, bus.dev_read_data};
  end

`ifdef MAGIC_READER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_stalls <= '0;
    end else begin
      if (push && stat_reads != '1) stat_reads <= stat_reads + 32'd1;
      if (state_q == StIssue && !bus.dev_read_valid && stat_stalls != '1) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

  assign bus.req_ready       = req_ready;
  assign bus.dev_read_ready  = dev_read_ready;
  assign bus.dev_read_select = sel_q;
  assign bus.resp_valid      = not_empty;
  assign bus.resp_data       = not_empty ? mem_q[rd_ptr_q][63:0] : '0;
  assign bus.resp_select     = not_empty ? mem_q[rd_ptr_q][75:64] : '0;
  assign busy                = (state_q != StIdle) || not_empty;

endmodule

// File: tb/tb_magic_device_reader.sv
// Directed and randomised bench for magic_device_reader with a queue-based reference model.
// Stat counters are checked when MAGIC_READER_STATS_EN is defined.
module tb_magic_device_reader;
  localparam int unsigned Depth = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;
`ifdef MAGIC_READER_STATS_EN
  logic [31:0] stat_reads, stat_stalls;
`endif

  always #5 clock = ~clock;

  magic_device_reader_if bus ();

  magic_device_reader #(.FIFO_DEPTH(Depth)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
`ifdef MAGIC_READER_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_stalls (stat_stalls)
`endif
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [63:0] dev_mem [4096];
  logic        dev_fire = 1'b0;
  logic [11:0] dev_sel_s = '0;

  // Reference model: read stage (0 none, 1 waiting on device, 2 data arriving) and a FIFO queue.
  int          stage = 0;
  logic [11:0] cur_sel = '0;
  logic [11:0] exp_dev_sel = '0;
  logic [75:0] fifo_q [$];
  int unsigned m_reads = 0, m_stalls = 0, obs_pops = 0;

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    int n;
    n = fifo_q.size();
    chk("req_ready", bus.req_ready, !reset && stage == 0 && n < Depth);
    chk("resp_valid", bus.resp_valid, n != 0);
    chk("dev_read_ready", bus.dev_read_ready, stage == 1);
    chk("dev_read_select", bus.dev_read_select, exp_dev_sel);
    chk("busy", busy, stage != 0 || n != 0);
    if (n != 0 && bus.resp_ready) chk("resp_head", {bus.resp_select, bus.resp_data}, fifo_q[0]);
`ifdef MAGIC_READER_STATS_EN
    chk("stat_reads", stat_reads, m_reads);
    chk("stat_stalls", stat_stalls, m_stalls);
`endif
    if (bus.resp_valid && bus.resp_ready) obs_pops++;
    dev_fire  = bus.dev_read_ready && bus.dev_read_valid;
    dev_sel_s = bus.dev_read_select;
    if (reset) begin
      stage = 0;
      fifo_q.delete();
      exp_dev_sel = '0;
      m_reads = 0;
      m_stalls = 0;
    end else begin
      if (n != 0 && bus.resp_ready) void'(fifo_q.pop_front());
      case (stage)
        0: if (bus.req_valid && n < Depth) begin
          stage = 1;
          cur_sel = bus.req_select;
          exp_dev_sel = bus.req_select;
        end
        1: if (bus.dev_read_valid) stage = 2; else m_stalls++;
        default: begin
          fifo_q.push_back({cur_sel, dev_mem[cur_sel]});
          m_reads++;
          stage = 0;
        end
      endcase
    end
  endtask

  // One cycle: check at the falling edge, then act as device one step after the rising edge.
  task automatic tick();
    @(negedge clock);
    observe();
    @(posedge clock);
    #1;
    bus.dev_read_data = dev_fire ? dev_mem[dev_sel_s] : {$urandom, $urandom};
  endtask

  task automatic do_read(input logic [11:0] sel);
    bit done = 0;
    bus.req_valid  = 1'b1;
    bus.req_select = sel;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.req_ready) done = 1;
      tick();
    end
    if (!done) chk("accept_timeout", bus.req_ready, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid      = 1'b0;
    bus.dev_read_valid = 1'b1;
    bus.resp_ready     = 1'b1;
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("drain_idle", busy, 0);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    int unsigned s0, p0;
    for (int i = 0; i < 4096; i++) dev_mem[i] = {$urandom, $urandom};
    dev_mem[12'h00A] = 64'hDEADBEEF_00000001;
    bus.req_valid      = 1'b0;
    bus.req_select     = '0;
    bus.resp_ready     = 1'b0;
    bus.dev_read_valid = 1'b1;
    bus.dev_read_data  = '0;
    @(posedge clock);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_dev_ready", bus.dev_read_ready, 0);
    chk("rst_dev_select", bus.dev_read_select, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_select", bus.resp_select, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single read latency
    do_read(12'h00A);
    tick();
    chk("single_not_yet", bus.resp_valid, 0);
    tick();
    chk("single_valid", bus.resp_valid, 1);
    chk("single_data", bus.resp_data, 64'hDEADBEEF_00000001);
    chk("single_select", bus.resp_select, 12'h00A);
    drain();

    // Fill to depth, blocked request, one pop reopens accept
    for (int i = 0; i < 4; i++) do_read(12'h200 + 12'(i));
    repeat (3) tick();
    bus.req_valid  = 1'b1;
    bus.req_select = 12'h204;
    repeat (2) tick();
    chk("full_blocked", bus.req_ready, 0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("full_pop_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    repeat (3) tick();
    drain();

    // Device stall for five cycles
    s0 = m_stalls;
    bus.dev_read_valid = 1'b0;
    do_read(12'h3A5);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", bus.dev_read_ready, 1);
      chk("stall_select", bus.dev_read_select, 12'h3A5);
      tick();
    end
`ifdef MAGIC_READER_STATS_EN
    chk("stall_count", stat_stalls, s0 + 5);
`endif
    bus.dev_read_valid = 1'b1;
    drain();

    // Pointer wrap with continuous consumption
    p0 = obs_pops;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) do_read(12'h100 + 12'(i));
    drain();
    chk("wrap_pops", obs_pops - p0, 10);

    // Reset while in ISSUE aborts the read
    bus.dev_read_valid = 1'b0;
    do_read(12'h3C3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_dev_ready", bus.dev_read_ready, 0);
    chk("abort_resp_valid", bus.resp_valid, 0);
    chk("abort_busy", busy, 0);
    bus.dev_read_valid = 1'b1;
    repeat (4) tick();
    chk("abort_no_resp", bus.resp_valid, 0);

    // Simultaneous push and pop at count 3
    for (int i = 0; i < 3; i++) do_read(12'h300 + 12'(i));
    repeat (3) tick();
    do_read(12'h303);
    tick();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("pushpop_ready", bus.req_ready, 1);
    do_read(12'h304);
    repeat (3) tick();
    chk("pushpop_full", bus.req_ready, 0);
    drain();

    // Randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      bus.req_valid      = 1'($urandom % 2);
      bus.req_select     = 12'($urandom);
      bus.resp_ready     = ($urandom % 3) != 0;
      bus.dev_read_valid = ($urandom % 4) != 0;
      reset              = ($urandom % 97) == 0;
      tick();
    end
    reset = 1'b0;
    drain();
    chk("final_resp_valid", bus.resp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/magic_device_reader.md
MAGIC_DEVICE_READER -- requirements
Module: magic_device_reader

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, default 4, response FIFO entries (power of two, 2..16).
REQ-002 SHALL have port: clock  input  1  sampling clock, all logic on posedge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  requester presents a read.
REQ-005 SHALL have port: req_ready  output  1  block accepts the read this cycle.
REQ-006 SHALL have port: req_select  input  12  device read selector.
REQ-007 SHALL have port: resp_valid  output  1  FIFO head valid.
REQ-008 SHALL have port: resp_ready  input  1  consumer pops the head.
REQ-009 SHALL have port: resp_data  output  64  head data.
REQ-010 SHALL have port: resp_select  output  12  selector that produced the head data.
REQ-011 SHALL have port: dev_read_select  output  12  selector driven to the magic device.
REQ-012 SHALL have port: dev_read_ready  output  1  read strobe to the device.
REQ-013 SHALL have port: dev_read_valid  input  1  device can serve.
REQ-014 SHALL have port: dev_read_data  input  64  device data, valid the cycle after the dev_read_valid&&dev_read_ready cycle.
REQ-015 SHALL have port: busy  output  1  FSM not in IDLE or FIFO non-empty.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, CAPTURE.
REQ-017 IDLE: req_ready=1 iff FIFO count < FIFO_DEPTH; on req_valid&&req_ready latch req_select, go ISSUE.
REQ-018 ISSUE: dev_read_ready=1, dev_read_select=latched selector; on dev_read_valid go CAPTURE; otherwise stay in ISSUE.
REQ-019 CAPTURE: push {latched selector, dev_read_data} into FIFO, go IDLE; dev_read_ready=0.
REQ-020 Outside ISSUE, dev_read_ready SHALL be 0 and dev_read_select SHALL hold its last value.
REQ-021 Latency: request accept cycle N, dev strobe N+1 (device ready), FIFO push at end of N+2, resp_valid at N+3; sustained rate one read per 3 cycles.
REQ-022 FIFO: resp_valid=(count!=0); pop on resp_valid&&resp_ready; pointers wrap modulo FIFO_DEPTH.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including at count=FIFO_DEPTH-1 and count=1.
REQ-024 Simultaneous push and pop with an empty FIFO SHALL NOT occur (no bypass); push lands, resp_valid next cycle.
REQ-025 One read SHALL be in flight at most; req_ready=0 in ISSUE and CAPTURE.
REQ-026 Accept is gated on count only, because CAPTURE always finds space (IDLE checked count<FIFO_DEPTH and only pops occur meanwhile).
REQ-027 resp_ready while resp_valid=0 SHALL be ignored (no underflow).

Reset
REQ-028 On reset: FSM=IDLE, FIFO count/pointers=0, resp_valid=0, dev_read_ready=0, dev_read_select=0, busy=0; resp_data/resp_select=0.
REQ-029 Reset asserted in ISSUE or CAPTURE SHALL abort the read; the pending datum is discarded, never pushed.
REQ-030 req_ready SHALL be 0 during reset cycles.

Configuration
REQ-031 Macro MAGIC_READER_STATS_EN SHALL add outputs stat_reads (32-bit, increments per FIFO push) and stat_stalls (32-bit, increments per ISSUE cycle with dev_read_valid=0), both saturating at 0xFFFFFFFF, cleared by reset.
REQ-032 Without MAGIC_READER_STATS_EN the ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-033 Single read: req_select=0x00A accepted cycle 1, dev_read_data=0xDEADBEEF_00000001 -> resp_valid cycle 4, resp_data=0xDEADBEEF00000001, resp_select=0x00A.
REQ-034 Full: resp_ready=0, 4 reads issued -> count=4, req_ready=0 with req_valid held; one pop -> req_ready=1 next cycle, 5th read completes.
REQ-035 Device stall: dev_read_valid=0 for 5 cycles in ISSUE -> dev_read_ready held 1, select stable, stat_stalls=5 (with macro), then completes normally.
REQ-036 Wrap: 10 reads selectors 0x100..0x109 with resp_ready=1 -> responses in order, selectors match, no loss or duplicate.
REQ-037 Reset mid-ISSUE: reset one cycle in ISSUE -> dev_read_ready=0, resp_valid=0, busy=0 next cycle; no response for the aborted selector.
REQ-038 Simultaneous push/pop at count=3 (FIFO_DEPTH=4) -> count stays 3, ordering preserved.
